// File: rtl/cc_pkg.sv
// cc_pkg: shared CC link definitions for the serial transmitter and receiver.
package cc_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WRITE, BREAK} cc_state_e;
`ifdef CFDR
    localparam int CC_SUBFRAME = 2048;
`else
    localparam int CC_SUBFRAME = 48;
`endif
    localparam int CC_BIT_PERIOD = 51;
endpackage

// File: rtl/cc_rx_sync.sv
// cc_rx_sync: two-flop synchroniser for the serial line plus falling-edge detect.
module cc_rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);
    logic [1:0] sync_q;
    logic       prev_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            prev_q <= sync_q[1];
        end
    end
    assign rx_s_o = sync_q[1];
    assign fall_o = prev_q & ~sync_q[1];
endmodule

// File: rtl/cc_receive.sv
// cc_receive: 8N1 serial byte receiver writing bytes to a buffer and flagging
// completed frames of SUBFRAME bytes.
module cc_receive import cc_pkg::*; #(
    parameter int SUBFRAME     = CC_SUBFRAME,
    parameter int BIT_PERIOD   = CC_BIT_PERIOD,
    parameter int IDLE_TIMEOUT = 4096,
    parameter int AW           = 12
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rx,
    output logic [AW-1:0] wraddress,
    output logic [7:0]    wrdata,
    output logic          wren,
    output logic          frame_done,
    output logic          frame_err,
    output logic          busy
);
    localparam int BW = $clog2(BIT_PERIOD) + 1;
    localparam int IW = $clog2(IDLE_TIMEOUT) + 1;
    localparam int CW = 13;
    localparam logic [BW-1:0] HALF_T = BW'(BIT_PERIOD / 2 - 1);
    localparam logic [BW-1:0] BIT_T  = BW'(BIT_PERIOD - 1);
    localparam logic [IW-1:0] IDLE_T = IW'(IDLE_TIMEOUT - 1);
    localparam logic [CW-1:0] SF_C   = CW'(SUBFRAME);

    cc_state_e     state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d, wrdata_q, wrdata_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wren_q, wren_d, done_q, done_d, err_q, err_d;
    logic          rx_s, fall;

    cc_rx_sync u_sync (
        .clock  (clock),
        .reset  (reset),
        .rx_i   (rx),
        .rx_s_o (rx_s),
        .fall_o (fall)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            wrdata_q <= '0;
            idle_q   <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            wren_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            wrdata_q <= wrdata_d;
            idle_q   <= idle_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            wren_q   <= wren_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        wrdata_d = wrdata_q;
        idle_d   = idle_q;
        count_d  = count_q;
        addr_d   = addr_q;
        wren_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = START;
                    idle_d  = '0;
                end else if (count_q != '0) begin
                    // a partial frame left idle too long is abandoned
                    if (idle_q == IDLE_T) begin
                        err_d   = 1'b1;
                        count_d = '0;
                        addr_d  = '0;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            START: begin
                if (cnt_q == HALF_T) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_T) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 1'b1;
                    state_d        = (idx_q == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                if (cnt_q == BIT_T) begin
                    cnt_d    = '0;
                    state_d  = rx_s ? WRITE : BREAK;
                    wren_d   = rx_s;
                    wrdata_d = rx_s ? shift_q : wrdata_q;
                    err_d    = ~rx_s;
                end
            end
            WRITE: begin
                cnt_d   = '0;
                state_d = IDLE;
                done_d  = (count_q + 1'b1 == SF_C);
                count_d = done_d ? '0 : count_q + 1'b1;
                addr_d  = done_d ? '0 : addr_q + 1'b1;
            end
            BREAK: begin
                cnt_d   = '0;
                state_d = rx_s ? IDLE : BREAK;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wraddress  = addr_q;
    assign wrdata     = wrdata_q;
    assign wren       = wren_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_cc_receive.sv
// tb_cc_receive: directed/random serial stimulus against a byte-level model of the receiver.
module tb_cc_receive;
    localparam int BP = 51;
    localparam int SF = 48;
    localparam int TO = 4096;
    localparam int AW = 12;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rx    = 1'b1;
    logic [AW-1:0] wraddress;
    logic [7:0]    wrdata;
    logic          wren, frame_done, frame_err, busy;

    int checks = 0, errors = 0;
    int fd_cnt = 0, fe_cnt = 0, both_cnt = 0;
    int exp_addr = 0, exp_fd = 0, exp_fe = 0;
    logic [19:0] got_q[$];
    logic [19:0] exp_q[$];

    cc_receive #(.SUBFRAME(SF), .BIT_PERIOD(BP), .IDLE_TIMEOUT(TO), .AW(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .wraddress  (wraddress),
        .wrdata     (wrdata),
        .wren       (wren),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #2;
        if (wren) got_q.push_back({wraddress, wrdata});
        if (frame_done) fd_cnt++;
        if (frame_err) fe_cnt++;
        if (frame_done && frame_err) both_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int stop_len);
        rx = 1'b0;
        tick(BP);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BP);
        end
        rx = stop;
        tick(stop_len);
    endtask

    // model: a good byte lands at the next address; a full frame wraps to 0
    task automatic tx_good(input logic [7:0] b, input int stop_len);
        send_byte(b, 1'b1, stop_len);
        exp_q.push_back({AW'(exp_addr), b});
        exp_addr++;
        if (exp_addr == SF) begin
            exp_addr = 0;
            exp_fd++;
        end
    endtask

    task automatic compare(input string tag);
        check({tag, "_nwr"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_wr"}, got_q[i], exp_q[i]);
        check({tag, "_addr"}, wraddress, exp_addr);
        check({tag, "_done"}, fd_cnt, exp_fd);
        check({tag, "_err"}, fe_cnt, exp_fe);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx = 1'b1;
        tick(2);
        reset = 1'b0;
        exp_addr = 0;
        tick(5);
    endtask

    initial begin
        logic [7:0] b;
        tick(3);
        check("rst_wraddress", wraddress, 0);
        check("rst_wrdata", wrdata, 0);
        check("rst_wren", wren, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", frame_err, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        tick(10);

        tx_good(8'hA5, 98);
        tick(5);
        compare("single");

        do_reset();
        for (int i = 0; i < SF; i++) tx_good(8'(i), $urandom_range(97, 140));
        tick(5);
        compare("frame");

        for (int i = 0; i < 3; i++) tx_good(8'($urandom), $urandom_range(97, 130));
        send_byte(8'($urandom), 1'b0, 200);
        exp_fe++;
        check("break_busy", busy, 1);
        compare("stop_err");
        rx = 1'b1;
        tick(100);
        check("break_exit", busy, 0);
        tx_good(8'($urandom), 98);
        tick(5);
        compare("after_err");

        rx = 1'b0;
        tick(10);
        rx = 1'b1;
        tick(60);
        check("glitch_idle", busy, 0);
        rx = 1'b0;
        tick($urandom_range(1, 20));
        rx = 1'b1;
        tick(60);
        compare("glitch");

        do_reset();
        for (int i = 0; i < 5; i++) tx_good(8'($urandom), 98);
        tick(3900);
        check("timeout_early", fe_cnt, exp_fe);
        for (int n = 0; n < 400 && fe_cnt == exp_fe; n++) tick(1);
        exp_fe++;
        exp_addr = 0;
        tick(3);
        compare("timeout");
        tx_good(8'($urandom), 98);
        tick(5);
        compare("post_timeout");

        do_reset();
        tx_good(8'($urandom), 98);
        b = 8'($urandom);
        rx = 1'b0;
        tick(BP);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick(BP);
        end
        tick(20);
        reset = 1'b1;
        rx = 1'b1;
        tick(1);
        check("midrst_wraddress", wraddress, 0);
        check("midrst_wrdata", wrdata, 0);
        check("midrst_wren", wren, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err", frame_err, 0);
        reset = 1'b0;
        exp_addr = 0;
        tick(60);
        tx_good(8'h3C, 98);
        tick(5);
        compare("post_reset");

        check("never_both", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
